ehl_gpio_irq: RTL and testbench

// - Per-pin interrupt detector; sits directly downstream of the GPIO input filter and consumes its filtered data.
// - Detects level or edge events per pin and latches them into a sticky status vector (isr).
// - isr is write-1-to-clear by the register block; a masked OR of isr drives a single registered interrupt line.

---
 rtl/ehl_gpio_irq.sv | 85 ++++++++
 tb/tb_ehl_gpio_irq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ehl_gpio_irq.sv
// Per-pin level/edge interrupt detector with sticky W1C status and a registered irq line.
// Define EHL_GPIO_IRQ_FIRST_EN to build first-event capture (first_vld/first_idx).
module ehl_gpio_irq #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned IDXW  = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] din,
   input  logic [WIDTH-1:0] itype,
   input  logic [WIDTH-1:0] ipol,
   input  logic [WIDTH-1:0] iboth,
   input  logic [WIDTH-1:0] ier,
   input  logic [WIDTH-1:0] isr_clr,
   output logic [WIDTH-1:0] isr,
   output logic             irq,
   output logic             first_vld,
   output logic [IDXW-1:0]  first_idx
);

   logic [WIDTH-1:0] din_q;
   logic             armed_q;
   logic [WIDTH-1:0] isr_q, isr_d;
   logic             irq_q;
   logic [WIDTH-1:0] rise, fall, edge_ev, lvl_ev, ev;

   always_comb begin
      rise    = din & ~din_q;
      fall    = ~din & din_q;
      edge_ev = (iboth & (rise | fall)) | (~iboth & ((ipol & rise) | (~ipol & fall)));
      lvl_ev  = ~(din ^ ipol);
      // Edges are masked until the first clock after reset so din_q catching up is not an event.
      ev      = (~itype & lvl_ev) | (itype & edge_ev & {WIDTH{armed_q}});
      isr_d   = (isr_q & ~isr_clr) | ev;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         din_q   <= '0;
         armed_q <= 1'b0;
         isr_q   <= '0;
         irq_q   <= 1'b0;
      end else begin
         din_q   <= din;
         armed_q <= 1'b1;
         isr_q   <= isr_d;
         irq_q   <= |(isr_q & ier);
      end
   end

   assign isr = isr_q;
   assign irq = irq_q;

`ifdef EHL_GPIO_IRQ_FIRST_EN
   logic            first_vld_q;
   logic [IDXW-1:0] first_idx_q;
   logic [IDXW-1:0] ev_low_idx;

   always_comb begin
      ev_low_idx = '0;
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
         if (ev[i]) ev_low_idx = IDXW'(i);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         first_vld_q <= 1'b0;
         first_idx_q <= '0;
      end else if ((isr_q == '0) && (ev != '0)) begin
         first_vld_q <= 1'b1;
         first_idx_q <= ev_low_idx;
      end else if (isr_d == '0) begin
         first_vld_q <= 1'b0;
      end
   end

   assign first_vld = first_vld_q;
   assign first_idx = first_idx_q;
`else
   assign first_vld = 1'b0;
   assign first_idx = '0;
`endif

endmodule

// File: tb/tb_ehl_gpio_irq.sv
// Directed bench for ehl_gpio_irq: per-cycle comparison against a pin-level behavioural model
// plus hand-computed checkpoints.
module tb_ehl_gpio_irq;
   localparam int W  = 8;
   localparam int IW = 3;

   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic [W-1:0]  din = '0, itype = '0, ipol = '0, iboth = '0, ier = '0, isr_clr = '0;
   logic [W-1:0]  isr;
   logic          irq, first_vld;
   logic [IW-1:0] first_idx;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   ehl_gpio_irq #(.WIDTH(W), .IDXW(IW)) dut (
      .clk(clk), .reset_n(reset_n), .din(din), .itype(itype), .ipol(ipol), .iboth(iboth),
      .ier(ier), .isr_clr(isr_clr), .isr(isr), .irq(irq), .first_vld(first_vld),
      .first_idx(first_idx)
   );

   always #5 clk = ~clk;

   // Behavioural model: per-pin reasoning about the level seen and the value before it.
   logic [W-1:0]  m_isr, m_prev;
   bit            m_armed, m_irq, m_fv;
   int            m_fi;

   task automatic model_clear();
      m_isr = '0; m_prev = '0; m_armed = 0; m_irq = 0; m_fv = 0; m_fi = 0;
   endtask

   task automatic model_step();
      logic [W-1:0] ev, nxt;
      bit hit, found;
      ev = '0;
      for (int i = 0; i < W; i++) begin
         if (!itype[i])               hit = (din[i] == ipol[i]);
         else if (!m_armed)           hit = 0;
         else if (din[i] == m_prev[i]) hit = 0;
         else if (iboth[i])           hit = 1;
         else                         hit = (din[i] == ipol[i]); // new level names the edge
         ev[i] = hit;
      end
      m_irq = 0;
      for (int i = 0; i < W; i++) if (m_isr[i] && ier[i]) m_irq = 1;
      nxt = '0;
      for (int i = 0; i < W; i++) nxt[i] = ev[i] ? 1'b1 : (isr_clr[i] ? 1'b0 : m_isr[i]);
`ifdef EHL_GPIO_IRQ_FIRST_EN
      if (m_isr == '0 && ev != '0) begin
         found = 0;
         for (int i = 0; i < W; i++) if (ev[i] && !found) begin m_fi = i; found = 1; end
         m_fv = 1;
      end else if (nxt == '0) begin
         m_fv = 0;
      end
`else
      found = 0;
`endif
      m_isr   = nxt;
      m_prev  = din;
      m_armed = 1;
   endtask

   initial begin
      model_clear();
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) model_clear();
         else          model_step();
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            check("model_isr", int'(isr), int'(m_isr));
            check("model_irq", int'(irq), int'(m_irq));
            check("model_first_vld", int'(first_vld), int'(m_fv));
            check("model_first_idx", int'(first_idx), m_fi);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #1 reset_n = 1'b0;
      itype = 8'hFF; ipol = 8'hFF; din = 8'hFF;
      #1 chk_en = 1'b1;
      tick(); tick();
      check("reset_isr", int'(isr), 0);
      check("reset_irq", int'(irq), 0);
      check("reset_first_vld", int'(first_vld), 0);
      // Release with all pins high in rising-edge mode: nothing may latch.
      reset_n = 1'b1;
      tick(); tick();
      check("armed_suppress_isr", int'(isr), 0);
      din = 8'h00; tick();

      // Pin3 rising edge.
      ier = 8'h08; din = 8'h08; tick();
      check("p3_isr_set", int'(isr), 8'h08);
      check("p3_irq_lag", int'(irq), 0);
      tick();
      check("p3_irq_high", int'(irq), 1);
      isr_clr = 8'h08; tick(); isr_clr = '0;
      check("p3_isr_cleared", int'(isr), 0);
      tick();
      check("p3_irq_low", int'(irq), 0);

      // Pin0 both edges, W1C between.
      iboth = 8'h01; ier = 8'h01; din = 8'h09; tick();
      check("p0_rise_isr", int'(isr), 8'h01);
      tick();
      check("p0_rise_irq", int'(irq), 1);
      isr_clr = 8'h01; tick(); isr_clr = '0; tick();
      check("p0_irq_drop", int'(irq), 0);
      din = 8'h08; tick();
      check("p0_fall_isr", int'(isr), 8'h01);
      tick();
      check("p0_fall_irq", int'(irq), 1);
      isr_clr = 8'h01; tick(); isr_clr = '0; tick();

      // Pin5 low level: clears ineffective while level persists.
      itype = 8'hDF; ipol = 8'hDF; ier = 8'h20; tick();
      check("p5_level_set", int'(isr), 8'h20);
      isr_clr = 8'h20;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("p5_level_sticky", int'(isr), 8'h20);
      end
      isr_clr = '0; din = 8'h28; tick();
      isr_clr = 8'h20; tick(); isr_clr = '0;
      check("p5_cleared", int'(isr), 0);
      tick();

      // Pin2 event and clear in the same cycle: set wins; ier gates irq only.
      itype = 8'hFF; ipol = 8'hFF; ier = 8'h00; din = 8'h2C; isr_clr = 8'h04; tick();
      isr_clr = '0;
      check("p2_set_beats_clr", int'(isr), 8'h04);
      tick(); tick();
      check("p2_masked_irq", int'(irq), 0);
      ier = 8'h04; tick();
      check("p2_unmask_irq", int'(irq), 1);
      isr_clr = 8'hFF; tick(); isr_clr = '0;

      // First-event capture: pins 2 and 4 together, then pin 7.
      din = 8'h28; tick();
      din = 8'h3C; tick();
      check("first_isr", int'(isr), 8'h14);
`ifdef EHL_GPIO_IRQ_FIRST_EN
      check("first_vld_set", int'(first_vld), 1);
      check("first_idx_low", int'(first_idx), 2);
`else
      check("first_vld_tied", int'(first_vld), 0);
`endif
      din = 8'hBC; tick();
      check("first_later_isr", int'(isr), 8'h94);
`ifdef EHL_GPIO_IRQ_FIRST_EN
      check("first_idx_held", int'(first_idx), 2);
`endif
      isr_clr = 8'hFF; tick(); isr_clr = '0;
      check("first_vld_clear", int'(first_vld), 0);

      // Async reset with isr full.
      itype = 8'h00; din = 8'hFF; tick();
      check("pre_reset_isr", int'(isr), 8'hFF);
      #1 reset_n = 1'b0;
      #1;
      check("async_isr", int'(isr), 0);
      check("async_irq", int'(irq), 0);
      check("async_first_vld", int'(first_vld), 0);
      tick();
      reset_n = 1'b1;
      tick(); tick(); tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
